// File: rtl/accuracy_tracker.sv
// Compares each training case's thresholded output against the ideal vector and keeps
// sliding-window, cumulative and per-epoch accuracy stats. Define ACC_TRACKER_EPOCH_EN for epoch counting.
module accuracy_tracker #(
  parameter int n_out          = 16,
  parameter int y_per_clk      = 1,
  parameter int cpc            = 18,
  parameter int checklast      = 1000,
  parameter int training_cases = 10000,
  parameter int cnt_width      = 32
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [$clog2(cpc)-1:0]         cycle_index,
  input  logic                           case_end,
  input  logic [y_per_clk-1:0]           y_out,
  input  logic [n_out-1:0]               a_out,
  output logic                           result_valid,
  output logic                           correct,
  output logic [$clog2(checklast+1)-1:0] recent,
  output logic [cnt_width-1:0]           total_correct,
  output logic [cnt_width-1:0]           num_train,
  output logic [15:0]                    epoch,
  output logic                           epoch_done
);
  localparam int CIW = $clog2(cpc);
  localparam int RW  = $clog2(checklast + 1);
  localparam int PW  = (checklast > 1) ? $clog2(checklast) : 1;

  logic [n_out-1:0]     ideal_q, ideal_d, ideal_cur, cap_mask, cap_val;
  logic [checklast-1:0] ring_q, ring_d;
  logic [PW-1:0]        ptr_q, ptr_d;
  logic [RW-1:0]        recent_q, recent_d;
  logic [cnt_width-1:0] tot_q, tot_d, nt_q, nt_d;
  logic                 correct_q, correct_d, valid_q, valid_d;

  // Slots captured this clk; ideal_cur bypasses them so an evaluation on the same edge sees y_out.
  always_comb begin
    cap_mask = '0;
    cap_val  = '0;
    if (cycle_index >= CIW'(2)) begin
      for (int i = 0; i < n_out; i++) begin
        for (int j = 0; j < y_per_clk; j++) begin
          if ((int'(cycle_index) - 2) * y_per_clk + j == i) begin
            cap_mask[i] = 1'b1;
            cap_val[i]  = y_out[j];
          end
        end
      end
    end
    ideal_cur = (ideal_q & ~cap_mask) | cap_val;
  end

  always_comb begin
    ideal_d   = ideal_cur;
    ring_d    = ring_q;
    ptr_d     = ptr_q;
    recent_d  = recent_q;
    tot_d     = tot_q;
    nt_d      = nt_q;
    correct_d = correct_q;
    valid_d   = 1'b0;
    if (case_end) begin
      correct_d     = (a_out == ideal_cur);
      valid_d       = 1'b1;
      // Next case starts from a clean vector, keeping only slots written on this edge.
      ideal_d       = cap_val;
      ring_d[ptr_q] = correct_d;
      recent_d      = recent_q - RW'(ring_q[ptr_q]) + RW'(correct_d);
      ptr_d         = (ptr_q == PW'(checklast - 1)) ? '0 : ptr_q + PW'(1);
      if (nt_q != '1)
        nt_d = nt_q + cnt_width'(1);
      if (correct_d && tot_q != '1)
        tot_d = tot_q + cnt_width'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ideal_q   <= '0;
      ring_q    <= '0;
      ptr_q     <= '0;
      recent_q  <= '0;
      tot_q     <= '0;
      nt_q      <= '0;
      correct_q <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      ideal_q   <= ideal_d;
      ring_q    <= ring_d;
      ptr_q     <= ptr_d;
      recent_q  <= recent_d;
      tot_q     <= tot_d;
      nt_q      <= nt_d;
      correct_q <= correct_d;
      valid_q   <= valid_d;
    end
  end

  assign result_valid  = valid_q;
  assign correct       = correct_q;
  assign recent        = recent_q;
  assign total_correct = tot_q;
  assign num_train     = nt_q;

`ifdef ACC_TRACKER_EPOCH_EN
  localparam int TW = (training_cases > 1) ? $clog2(training_cases) : 1;

  logic [TW-1:0] tc_q, tc_d;
  logic [15:0]   epoch_q, epoch_d;
  logic          edone_q, edone_d;

  always_comb begin
    tc_d    = tc_q;
    epoch_d = epoch_q;
    edone_d = 1'b0;
    if (case_end) begin
      if (tc_q == TW'(training_cases - 1)) begin
        tc_d    = '0;
        epoch_d = epoch_q + 16'd1;
        edone_d = 1'b1;
      end else begin
        tc_d = tc_q + TW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tc_q    <= '0;
      epoch_q <= '0;
      edone_q <= 1'b0;
    end else begin
      tc_q    <= tc_d;
      epoch_q <= epoch_d;
      edone_q <= edone_d;
    end
  end

  assign epoch      = epoch_q;
  assign epoch_done = edone_q;
`else
  assign epoch      = '0;
  assign epoch_done = 1'b0;
`endif

endmodule

// File: tb/tb_accuracy_tracker.sv
// Directed bench: a default-size tracker and a small one (checklast=4, training_cases=3,
// cnt_width=3) share the same stimulus; expectations are hand-computed tables.
module tb_accuracy_tracker;
`ifdef ACC_TRACKER_EPOCH_EN
  localparam int EP = 1;
`else
  localparam int EP = 0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  cycle_index;
  logic        case_end;
  logic [0:0]  y_out;
  logic [15:0] a_out;

  logic        d_valid, d_correct, d_edone;
  logic [9:0]  d_recent;
  logic [31:0] d_tot, d_nt;
  logic [15:0] d_epoch;
  logic        s_valid, s_correct, s_edone;
  logic [2:0]  s_recent, s_tot, s_nt;
  logic [15:0] s_epoch;

  int n_chk = 0;
  int n_err = 0;

  accuracy_tracker dut_d (
    .clk(clk), .reset(reset), .cycle_index(cycle_index), .case_end(case_end),
    .y_out(y_out), .a_out(a_out), .result_valid(d_valid), .correct(d_correct),
    .recent(d_recent), .total_correct(d_tot), .num_train(d_nt),
    .epoch(d_epoch), .epoch_done(d_edone)
  );

  accuracy_tracker #(.checklast(4), .training_cases(3), .cnt_width(3)) dut_s (
    .clk(clk), .reset(reset), .cycle_index(cycle_index), .case_end(case_end),
    .y_out(y_out), .a_out(a_out), .result_valid(s_valid), .correct(s_correct),
    .recent(s_recent), .total_correct(s_tot), .num_train(s_nt),
    .epoch(s_epoch), .epoch_done(s_edone)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Full block cycle: ideal bits on cycle_index 2..17, case_end on 17 (bypass slot 15).
  task automatic run_case(input logic [15:0] ideal, input logic [15:0] a);
    for (int ci = 0; ci < 18; ci++) begin
      @(negedge clk);
      cycle_index = 5'(ci);
      if (ci >= 2) y_out = ideal[ci-2];
      else         y_out = 1'b0;
      case_end = (ci == 17);
      a_out    = a;
    end
    @(negedge clk);
    cycle_index = '0;
    y_out       = '0;
    case_end    = 1'b0;
  endtask

  // Lone case_end at cycle_index 0: evaluates against whatever the ideal register holds.
  task automatic fire(input logic [15:0] a);
    @(negedge clk);
    cycle_index = '0;
    y_out       = '0;
    case_end    = 1'b1;
    a_out       = a;
    @(negedge clk);
    case_end    = 1'b0;
  endtask

  task automatic chk_res(input string tag, input logic c, input int drec, input int srec,
                         input int dnt, input int snt, input int dtot, input int stot);
    chk($sformatf("%s.valid_d", tag), d_valid, 1);
    chk($sformatf("%s.valid_s", tag), s_valid, 1);
    chk($sformatf("%s.correct_d", tag), d_correct, c);
    chk($sformatf("%s.correct_s", tag), s_correct, c);
    chk($sformatf("%s.recent_d", tag), d_recent, drec);
    chk($sformatf("%s.recent_s", tag), s_recent, srec);
    chk($sformatf("%s.num_train_d", tag), d_nt, dnt);
    chk($sformatf("%s.num_train_s", tag), s_nt, snt);
    chk($sformatf("%s.total_d", tag), d_tot, dtot);
    chk($sformatf("%s.total_s", tag), s_tot, stot);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; case_end = 1'b0; cycle_index = '0; y_out = '0; a_out = '0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  int   srec_t [11] = '{1, 2, 3, 4, 3, 2, 2, 2, 3, 4, 4};
  int   cum_t  [11] = '{1, 2, 3, 4, 4, 4, 5, 6, 7, 8, 9};
  logic res_t  [11] = '{1, 1, 1, 1, 0, 0, 1, 1, 1, 1, 1};

  initial begin
    do_reset();
    chk("rst.valid", d_valid, 0);
    chk("rst.correct", s_correct, 0);
    chk("rst.recent_d", d_recent, 0);
    chk("rst.num_train_s", s_nt, 0);
    chk("rst.total_d", d_tot, 0);
    chk("rst.epoch_s", s_epoch, 0);

    // Phase A: full-cycle cases, bypass, stale-register evaluation
    run_case(16'hFFFF, 16'hFFFF);
    chk_res("c1", 1'b1, 1, 1, 1, 1, 1, 1);
    chk("c1.edone_s", s_edone, 0);
    @(negedge clk);
    chk("c1.valid_drop_d", d_valid, 0);
    chk("c1.valid_drop_s", s_valid, 0);
    run_case(16'hFFFF, 16'hFFFE);
    chk_res("c2", 1'b0, 1, 1, 2, 2, 1, 1);
    run_case(16'hA5C3, 16'hA5C3);
    chk_res("c3", 1'b1, 2, 2, 3, 3, 2, 2);
    chk("c3.edone_s", s_edone, EP);
    chk("c3.epoch_s", s_epoch, EP);
    chk("c3.edone_d", d_edone, 0);
    // only slot 15 (captured on the evaluation edge) survives the clear
    fire(16'h8000);
    chk_res("c4", 1'b1, 3, 3, 4, 4, 3, 3);
    chk("c4.edone_s", s_edone, 0);
    fire(16'h0000);
    chk_res("c5", 1'b1, 4, 3, 5, 5, 4, 4);

    // Phase B: reset dominates a coincident case_end and capture
    @(negedge clk);
    reset = 1'b1; case_end = 1'b1; cycle_index = 5'd2; y_out = 1'b1; a_out = '0;
    @(negedge clk);
    reset = 1'b0; case_end = 1'b0; cycle_index = '0; y_out = '0;
    chk("rc.valid_d", d_valid, 0);
    chk("rc.valid_s", s_valid, 0);
    chk("rc.recent_d", d_recent, 0);
    chk("rc.recent_s", s_recent, 0);
    chk("rc.num_train_d", d_nt, 0);
    chk("rc.total_d", d_tot, 0);
    chk("rc.correct_s", s_correct, 0);
    chk("rc.epoch_s", s_epoch, 0);
    fire(16'h0000);
    chk_res("rc.after", 1'b1, 1, 1, 1, 1, 1, 1);

    // Phase C: window wrap, saturation, epochs
    do_reset();
    for (int i = 0; i < 11; i++) begin
      fire(res_t[i] ? 16'h0000 : 16'h0001);
      chk_res($sformatf("w%0d", i), res_t[i], cum_t[i], srec_t[i], i + 1,
              (i + 1 > 7) ? 7 : i + 1, cum_t[i], (cum_t[i] > 7) ? 7 : cum_t[i]);
      chk($sformatf("w%0d.epoch_s", i), s_epoch, EP * ((i + 1) / 3));
      chk($sformatf("w%0d.edone_s", i), s_edone, EP * ((i % 3 == 2) ? 1 : 0));
      chk($sformatf("w%0d.epoch_d", i), d_epoch, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no end, expected finish");
    $fatal(1);
  end
endmodule
